halfword_packer: RTL and testbench

Narrowing store-path packer for the Lapido datapath, the counterpart of immediate sign extension: converts 32-bit register values to 16-bit signed halfwords and packs two consecutive halfwords into one 32-bit memory write word. It sits between the register-file read port and the data-memory write buffer. It checks each value for 16-bit representability, flags values that do not fit, and counts such overflows.

---
 rtl/halfword_packer.sv | 190 +++++++++++++++++++
 tb/tb_halfword_packer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/halfword_packer.sv
// -----------------------------------------------------------------------------
// halfword_packer
//
// Narrowing store-path packer. Each accepted 32-bit signed register value is
// narrowed to a 16-bit halfword. Two consecutive halfwords are packed into one
// 32-bit memory write word, with the earlier value in the low half. A
// half-filled word can be closed early with flush. The low half is then valid
// and the high half reads as zero.
//
// A value is representable when in_data[31:15] is all zeros or all ones. If it
// is not, its per-half overflow flag is set and a saturating event counter is
// incremented.
//
// Optional feature (compile-time macro): HALFWORD_PACKER_SATURATE_EN
//   defined   : a non-representable value narrows to 16'h8000 (negative) or
//               16'h7FFF (positive).
//   undefined : a non-representable value is truncated to in_data[15:0].
//   In both builds, out_ovf and ovf_count behave the same way.
//
// Parameters
//   CNT_W      width of the saturating overflow event counter
//
// Ports
//   clk        clock; all state updates on the rising edge
//   reset      synchronous, active-high; clears all state and outputs
//   in_valid   producer presents a value on in_data
//   in_ready   packer can accept this cycle (combinational)
//   in_data    signed 32-bit value to narrow
//   flush      close a half-filled word (ignored unless one half is held)
//   out_valid  out_data/out_mask/out_ovf hold a complete word
//   out_ready  consumer accepts the word
//   out_data   {hi halfword, lo halfword}
//   out_mask   [0] lo valid, [1] hi valid
//   out_ovf    per-half overflow flags, same bit order as out_mask
//   ovf_count  accepted inputs with overflow, saturating at all ones
// -----------------------------------------------------------------------------
module halfword_packer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [1:0]       out_mask,
  output logic [1:0]       out_ovf,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HALF  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [15:0]      loData_q, loData_d;
  logic             loOvf_q, loOvf_d;
  logic             outValid_q, outValid_d;
  logic [31:0]      outData_q, outData_d;
  logic [1:0]       outMask_q, outMask_d;
  logic [1:0]       outOvf_q, outOvf_d;
  logic [CNT_W-1:0] ovfCount_q, ovfCount_d;

  logic             inOvf;
  logic [15:0]      inNarrow;
  logic             readyInt;
  logic             accept;
  logic             emit;

  // Bits 31..15 must all match the sign bit for the value to survive
  // narrowing unchanged.
  assign inOvf = !((&in_data[31:15]) || !(|in_data[31:15]));

`ifdef HALFWORD_PACKER_SATURATE_EN
  // Clamp out-of-range values toward the nearest 16-bit extreme.
  always_comb begin
    inNarrow = in_data[15:0];
    if (inOvf) begin
      inNarrow = in_data[31] ? 16'h8000 : 16'h7FFF;
    end
  end
`else
  assign inNarrow = in_data[15:0];
`endif

  // A full word blocks new input unless it leaves this same cycle.
  assign readyInt = (state_q != S_FULL) || out_ready;
  assign accept   = in_valid && readyInt;
  assign emit     = outValid_q && out_ready;

  always_comb begin
    state_d    = state_q;
    loData_d   = loData_q;
    loOvf_d    = loOvf_q;
    outData_d  = outData_q;
    outMask_d  = outMask_q;
    outOvf_d   = outOvf_q;

    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          loData_d = inNarrow;
          loOvf_d  = inOvf;
          state_d  = S_HALF;
        end
      end

      S_HALF: begin
        // A real second value takes priority over flush in the same cycle.
        if (accept) begin
          outData_d = {inNarrow, loData_q};
          outMask_d = 2'b11;
          outOvf_d  = {inOvf, loOvf_q};
          state_d   = S_FULL;
        end else if (flush) begin
          outData_d = {16'h0000, loData_q};
          outMask_d = 2'b01;
          outOvf_d  = {1'b0, loOvf_q};
          state_d   = S_FULL;
        end
      end

      S_FULL: begin
        // The word registers keep their value after emit. out_valid marks
        // them stale, so they need not be cleared.
        if (emit) begin
          if (accept) begin
            loData_d = inNarrow;
            loOvf_d  = inOvf;
            state_d  = S_HALF;
          end else begin
            state_d  = S_EMPTY;
          end
        end
      end

      default: begin
        state_d = S_EMPTY;
      end
    endcase

    outValid_d = (state_d == S_FULL);
  end

  // Count overflowing accepts, sticking at all ones instead of wrapping.
  always_comb begin
    ovfCount_d = ovfCount_q;
    if (accept && inOvf && (ovfCount_q != CntMax)) begin
      ovfCount_d = ovfCount_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_EMPTY;
      loData_q   <= '0;
      loOvf_q    <= 1'b0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outMask_q  <= '0;
      outOvf_q   <= '0;
      ovfCount_q <= '0;
    end else begin
      state_q    <= state_d;
      loData_q   <= loData_d;
      loOvf_q    <= loOvf_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outMask_q  <= outMask_d;
      outOvf_q   <= outOvf_d;
      ovfCount_q <= ovfCount_d;
    end
  end

  assign in_ready  = readyInt;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_mask  = outMask_q;
  assign out_ovf   = outOvf_q;
  assign ovf_count = ovfCount_q;

endmodule

// File: tb/tb_halfword_packer.sv
// -----------------------------------------------------------------------------
// tb_halfword_packer
//
// Testbench for halfword_packer. It drives two instances from the same inputs:
// one with the default 8-bit counter and one with a 2-bit counter, so that
// counter saturation is reached quickly.
//
// A behavioural reference model runs every cycle. It keeps a queue of pending
// halfwords and one expected output word, computed with plain signed
// arithmetic. The bench also applies directed table vectors and hand-written
// sequences, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_halfword_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        flush;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_mask;
  logic [1:0]  out_ovf;
  logic [7:0]  ovf_count;

  logic        satInReady;
  logic        satOutValid;
  logic [31:0] satOutData;
  logic [1:0]  satOutMask;
  logic [1:0]  satOutOvf;
  logic [1:0]  satOvfCount;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [16:0] pend[$];
  bit          wordValid;
  logic [31:0] wordData;
  logic [1:0]  wordMask;
  logic [1:0]  wordOvf;
  int          ovfEvents;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] expData;
    logic [1:0]  expOvf;
    int          expCount;
  } pairVec_t;

  pairVec_t vecs[6];

  always #5 clk = ~clk;

  halfword_packer #(.CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .out_ovf   (out_ovf),
    .ovf_count (ovf_count)
  );

  halfword_packer #(.CNT_W(2)) dutSat (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (satInReady),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (satOutValid),
    .out_ready (out_ready),
    .out_data  (satOutData),
    .out_mask  (satOutMask),
    .out_ovf   (satOutOvf),
    .ovf_count (satOvfCount)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d,
                               input logic f, input logic r);
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
  endtask

  // A value fits in 16 bits exactly when it lies in the signed halfword range.
  function automatic bit refOvf(input logic [31:0] v);
    int signed s;
    s = $signed(v);
    return (s < -32768) || (s > 32767);
  endfunction

  function automatic logic [15:0] refNarrow(input logic [31:0] v);
    int signed s;
    s = $signed(v);
`ifdef HALFWORD_PACKER_SATURATE_EN
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  // Advance the model by one clock using the inputs that are about to be
  // sampled.
  function automatic void modelStep();
    bit          full;
    bit          acc;
    bit          ovf;
    logic [15:0] n;
    if (reset) begin
      pend.delete();
      wordValid = 1'b0;
      wordData  = '0;
      wordMask  = '0;
      wordOvf   = '0;
      ovfEvents = 0;
      return;
    end
    full = wordValid;
    acc  = in_valid && (!full || out_ready);
    if (full && out_ready) wordValid = 1'b0;
    if (acc) begin
      ovf = refOvf(in_data);
      n   = refNarrow(in_data);
      if (ovf) ovfEvents++;
      pend.push_back({ovf, n});
      if (pend.size() == 2) begin
        wordData  = {pend[1][15:0], pend[0][15:0]};
        wordMask  = 2'b11;
        wordOvf   = {pend[1][16], pend[0][16]};
        wordValid = 1'b1;
        pend.delete();
      end
    end else if (flush && !full && pend.size() == 1) begin
      wordData  = {16'h0000, pend[0][15:0]};
      wordMask  = 2'b01;
      wordOvf   = {1'b0, pend[0][16]};
      wordValid = 1'b1;
      pend.delete();
    end
  endfunction

  task automatic checkModel();
    checkOutput("out_valid", 32'(out_valid), 32'(wordValid));
    checkOutput("in_ready", 32'(in_ready), 32'(!wordValid || out_ready));
    if (wordValid) begin
      checkOutput("out_data", out_data, wordData);
      checkOutput("out_mask", 32'(out_mask), 32'(wordMask));
      checkOutput("out_ovf", 32'(out_ovf), 32'(wordOvf));
    end
    checkOutput("ovf_count8", 32'(ovf_count), (ovfEvents > 255) ? 32'd255 : 32'(ovfEvents));
    checkOutput("ovf_count2", 32'(satOvfCount), (ovfEvents > 3) ? 32'd3 : 32'(ovfEvents));
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    checkModel();
  endtask

  function automatic logic [31:0] randValue();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h00007FFF;
      1: v = 32'hFFFF8000;
      2: v = 32'h00008000;
      3: v = 32'hFFFF7FFF;
      4: v = {{16{$urandom_range(0, 1) == 1}}, 16'($urandom())};
      default: v = $urandom();
    endcase
    return v;
  endfunction

  initial begin
    vecs[0] = '{32'h00001234, 32'hFFFF8000, 32'h80001234, 2'b00, 0};
`ifdef HALFWORD_PACKER_SATURATE_EN
    vecs[1] = '{32'h00012345, 32'hFFFE0000, 32'h80007FFF, 2'b11, 2};
    vecs[2] = '{32'h0000ABCD, 32'h00007FFF, 32'h7FFF7FFF, 2'b01, 3};
    vecs[3] = '{32'hFFFF7FFF, 32'hFFFF8000, 32'h80008000, 2'b01, 4};
    vecs[5] = '{32'h80000000, 32'h7FFFFFFF, 32'h7FFF8000, 2'b11, 6};
`else
    vecs[1] = '{32'h00012345, 32'hFFFE0000, 32'h00002345, 2'b11, 2};
    vecs[2] = '{32'h0000ABCD, 32'h00007FFF, 32'h7FFFABCD, 2'b01, 3};
    vecs[3] = '{32'hFFFF7FFF, 32'hFFFF8000, 32'h80007FFF, 2'b01, 4};
    vecs[5] = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFF0000, 2'b11, 6};
`endif
    vecs[4] = '{32'h00007FFF, 32'hFFFFFFFF, 32'hFFFF7FFF, 2'b00, 4};

    // Reset held for three cycles with live inputs
    reset = 1'b1;
    applyStimulus(1'b1, 32'h00012345, 1'b1, 1'b1);
    repeat (3) tick();
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data", out_data, 32'd0);
    checkOutput("reset out_mask", 32'(out_mask), 32'd0);
    checkOutput("reset out_ovf", 32'(out_ovf), 32'd0);
    checkOutput("reset ovf_count", 32'(ovf_count), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("post-reset out_valid", 32'(out_valid), 32'd0);

    // Table-driven pairs
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vecs[i].lo, 1'b0, 1'b1);
      tick();
      checkOutput("pair half out_valid", 32'(out_valid), 32'd0);
      applyStimulus(1'b1, vecs[i].hi, 1'b0, 1'b1);
      tick();
      checkOutput("pair out_valid", 32'(out_valid), 32'd1);
      checkOutput("pair out_data", out_data, vecs[i].expData);
      checkOutput("pair out_mask", 32'(out_mask), 32'd3);
      checkOutput("pair out_ovf", 32'(out_ovf), 32'(vecs[i].expOvf));
      checkOutput("pair ovf_count", 32'(ovf_count), 32'(vecs[i].expCount));
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      tick();
    end

    // Backpressure: hold a full word and offer new input
    applyStimulus(1'b1, 32'h00000011, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h00000022, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h00000099, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp out_data", out_data, 32'h00220011);
      checkOutput("bp in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp out_valid", 32'(out_valid), 32'd1);
    end
    applyStimulus(1'b1, 32'h00000007, 1'b0, 1'b1);
    tick();
    checkOutput("bp emit out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    checkOutput("bp held lo data", out_data, 32'h00000007);
    checkOutput("bp held lo mask", 32'(out_mask), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();

    // Flush cases
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    checkOutput("flush empty out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 32'h00000042, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    checkOutput("flush out_data", out_data, 32'h00000042);
    checkOutput("flush out_mask", 32'(out_mask), 32'd1);
    checkOutput("flush out_ovf", 32'(out_ovf), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h00000005, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h00000006, 1'b1, 1'b1);
    tick();
    checkOutput("flush+accept out_mask", 32'(out_mask), 32'd3);
    checkOutput("flush+accept out_data", out_data, 32'h00060005);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    checkOutput("flush in full out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("no extra word", 32'(out_valid), 32'd0);

    // Counter saturation: five overflowing inputs in a row
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 32'h00010000 * i, 1'b0, 1'b1);
      tick();
    end
    checkOutput("sat ovf_count CNT_W=2", 32'(satOvfCount), 32'd3);
    checkOutput("sat ovf_count CNT_W=8", 32'(ovf_count), 32'd5);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();

    // Randomized run against the reference model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      applyStimulus($urandom_range(0, 3) != 0, randValue(),
                    $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
